// File: rtl/xdma_meta_mgr.sv
// Tracks one outstanding XDMA write request: latches its ID and length, counts completed beats, and flags done.
// Optional macro XDMA_META_MGR_BEAT_CNT_EN adds beat_cnt_o and abort_o.
module xdma_meta_mgr #(
    parameter int ID_W  = 8,
    parameter int LEN_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ID_W+LEN_W-1:0] write_req_meta_i,
    input  logic                  write_req_busy_i,
    input  logic                  write_happening_i,
    output logic                  write_req_done_o,
    output logic [ID_W-1:0]       cur_dma_id_o
`ifdef XDMA_META_MGR_BEAT_CNT_EN
    ,
    output logic [LEN_W-1:0]      beat_cnt_o,
    output logic                  abort_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   cnt_inc;
    logic [ID_W-1:0]    meta_id;
    logic [LEN_W-1:0]   meta_len;
`ifdef XDMA_META_MGR_BEAT_CNT_EN
    logic               abort_q, abort_d;
`endif

    assign meta_id  = write_req_meta_i[ID_W+LEN_W-1:LEN_W];
    assign meta_len = write_req_meta_i[LEN_W-1:0];
    assign cnt_inc  = cnt_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        id_d    = id_q;
`ifdef XDMA_META_MGR_BEAT_CNT_EN
        abort_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (write_req_busy_i) begin
                    id_d    = meta_id;
                    len_d   = meta_len;
                    cnt_d   = '0;
                    state_d = (meta_len == '0) ? S_DONE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // A busy drop wins over a coincident beat strobe: the request is gone.
                if (!write_req_busy_i) begin
                    state_d = S_IDLE;
`ifdef XDMA_META_MGR_BEAT_CNT_EN
                    abort_d = 1'b1;
`endif
                end else if (write_happening_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!write_req_busy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            done_q  <= 1'b0;
`ifdef XDMA_META_MGR_BEAT_CNT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            id_q    <= id_d;
            done_q  <= done_d;
`ifdef XDMA_META_MGR_BEAT_CNT_EN
            abort_q <= abort_d;
`endif
        end
    end

    assign write_req_done_o = done_q;
    assign cur_dma_id_o     = id_q;
`ifdef XDMA_META_MGR_BEAT_CNT_EN
    assign beat_cnt_o       = cnt_q;
    assign abort_o          = abort_q;
`endif

endmodule

// File: tb/tb_xdma_meta_mgr.sv
// Directed and randomized bench for xdma_meta_mgr against a request-level model.
module tb_xdma_meta_mgr;
    localparam int ID_W  = 8;
    localparam int LEN_W = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [ID_W+LEN_W-1:0] write_req_meta_i = '0;
    logic                  write_req_busy_i = 1'b0;
    logic                  write_happening_i = 1'b0;
    logic                  write_req_done_o;
    logic [ID_W-1:0]       cur_dma_id_o;
`ifdef XDMA_META_MGR_BEAT_CNT_EN
    logic [LEN_W-1:0]      beat_cnt_o;
    logic                  abort_o;
`endif

    xdma_meta_mgr #(.ID_W(ID_W), .LEN_W(LEN_W)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .write_req_meta_i  (write_req_meta_i),
        .write_req_busy_i  (write_req_busy_i),
        .write_happening_i (write_happening_i),
        .write_req_done_o  (write_req_done_o),
        .cur_dma_id_o      (cur_dma_id_o)
`ifdef XDMA_META_MGR_BEAT_CNT_EN
        ,
        .beat_cnt_o        (beat_cnt_o),
        .abort_o           (abort_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Request-level model: beats still owed, whether a request is open, done flag, last ID.
    logic            m_open;
    logic            m_done;
    int              m_left;
    logic [ID_W-1:0] m_id;

    task automatic model_reset();
        m_open = 1'b0;
        m_done = 1'b0;
        m_left = 0;
        m_id   = '0;
    endtask

    task automatic model_edge(input logic b, input logic h, input logic [ID_W-1:0] id,
                              input logic [LEN_W-1:0] len);
        if (m_done) begin
            if (!b) m_done = 1'b0;
        end else if (m_open) begin
            if (!b) m_open = 1'b0;
            else if (h) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_open = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (b) begin
            m_id = id;
            if (len == 0) m_done = 1'b1;
            else begin
                m_open = 1'b1;
                m_left = int'(len);
            end
        end
    endtask

    task automatic check(input string tag);
        total++;
        assert (write_req_done_o === m_done)
        else begin
            bad++;
            $error("FAIL %s done: observed=%0b expected=%0b", tag, write_req_done_o, m_done);
        end
        total++;
        assert (cur_dma_id_o === m_id)
        else begin
            bad++;
            $error("FAIL %s id: observed=%0d expected=%0d", tag, cur_dma_id_o, m_id);
        end
    endtask

    task automatic step(input logic b, input logic h, input logic [ID_W-1:0] id,
                        input logic [LEN_W-1:0] len, input string tag);
        @(negedge clk_i);
        write_req_busy_i  = b;
        write_happening_i = h;
        write_req_meta_i  = {id, len};
        @(posedge clk_i);
        model_edge(b, h, id, len);
        #1;
        check(tag);
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ID_W'($urandom), LEN_W'($urandom), tag);
    endtask

    initial begin
        int   abort_en;
        int   cyc;
        logic b;
        logic [ID_W-1:0]  rid;
        logic [LEN_W-1:0] rlen;

        model_reset();
        // Reset and quiet idle
        #12;
        check("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'd0, 16'd0, "idle_hold");

        // Single beat
        idle_steps($urandom_range(1, 5), "sb_pre");
        step(1'b1, 1'b0, 8'd88, 16'd1, "sb_accept");
        for (int i = 0; i < int'($urandom_range(0, 4)); i++) step(1'b1, 1'b0, 8'd1, 16'd9, "sb_wait");
        step(1'b1, 1'b1, 8'd1, 16'd9, "sb_beat");
        step(1'b1, 1'b0, 8'd1, 16'd9, "sb_hold");
        step(1'b1, 1'b0, 8'd1, 16'd9, "sb_hold");
        step(1'b0, 1'b0, 8'd1, 16'd9, "sb_release");

        // Multi beat with gaps and strobes while done
        step(1'b1, 1'b0, 8'd5, 16'd4, "mb_accept");
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 8'd77, 16'd1, "mb_gap");
            step(1'b1, 1'b1, 8'd77, 16'd1, "mb_beat");
        end
        step(1'b1, 1'b1, 8'd66, 16'd0, "mb_done_strobe");
        step(1'b1, 1'b1, 8'd66, 16'd0, "mb_done_strobe");
        step(1'b0, 1'b0, 8'd0, 16'd0, "mb_release");

        // Zero length
        step(1'b1, 1'b0, 8'd3, 16'd0, "zl_accept");
        step(1'b0, 1'b0, 8'd0, 16'd0, "zl_release");

        // Abort then a normal request
        step(1'b1, 1'b0, 8'd9, 16'd3, "ab_accept");
        step(1'b1, 1'b1, 8'd9, 16'd3, "ab_beat");
        step(1'b1, 1'b1, 8'd9, 16'd3, "ab_beat");
        step(1'b0, 1'b0, 8'd9, 16'd3, "ab_drop");
        step(1'b0, 1'b1, 8'd9, 16'd3, "ab_idle");
        step(1'b1, 1'b0, 8'd10, 16'd1, "ab_next_accept");
        step(1'b1, 1'b1, 8'd10, 16'd1, "ab_next_beat");
        step(1'b0, 1'b0, 8'd10, 16'd1, "ab_next_release");

        // Asynchronous reset while active
        step(1'b1, 1'b0, 8'd7, 16'd2, "ar_accept");
        step(1'b1, 1'b1, 8'd7, 16'd2, "ar_beat");
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        check("ar_async");
        @(negedge clk_i);
        rst_i = 1'b0;
        write_req_busy_i = 1'b0;
        step(1'b0, 1'b0, 8'd7, 16'd2, "ar_idle");
        step(1'b1, 1'b0, 8'd42, 16'd2, "ar_fresh_accept");
        step(1'b1, 1'b1, 8'd0, 16'd0, "ar_fresh_beat");
        step(1'b1, 1'b1, 8'd0, 16'd0, "ar_fresh_beat");
        step(1'b0, 1'b0, 8'd0, 16'd0, "ar_fresh_release");

        // Randomized requests; metadata is scrambled after acceptance to prove it is ignored
        for (int r = 0; r < 40; r++) begin
            idle_steps($urandom_range(0, 2), "rnd_gap");
            rid      = ID_W'($urandom);
            rlen     = LEN_W'($urandom_range(0, 5));
            abort_en = ($urandom_range(0, 3) == 0) ? 1 : 0;
            step(1'b1, 1'($urandom_range(0, 1)), rid, rlen, "rnd_accept");
            cyc = 0;
            b   = 1'b1;
            while (!m_done && b && cyc < 60) begin
                b = (abort_en != 0 && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                step(b, 1'($urandom_range(0, 1)), ID_W'($urandom), LEN_W'($urandom), "rnd_run");
                cyc++;
            end
            if (m_done) begin
                for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                    step(1'b1, 1'($urandom_range(0, 1)), ID_W'($urandom), LEN_W'($urandom), "rnd_done_hold");
            end
            step(1'b0, 1'($urandom_range(0, 1)), ID_W'($urandom), LEN_W'($urandom), "rnd_release");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
